// File: rtl/updown_bcd_timer.sv
// Multi-digit up/down BCD timer with prescaler, load/clear, wrap or saturate
// at the boundaries, and 7-segment (active-low) decode of every digit.
module updown_bcd_timer #(
   parameter int DIGITS   = 2,
   parameter int TICK_DIV = 50000000,
   parameter int BLANK_LZ = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  en,
   input  logic                  up,
   input  logic                  wrap,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   hex,
   output logic                  tc
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   logic [PW-1:0]       presc;
   logic                tick;
   logic [4*DIGITS-1:0] inc_val;
   logic [4*DIGITS-1:0] dec_val;
   logic [4*DIGITS-1:0] clamp_val;
   logic                carry;
   logic                borrow;
   logic                seen_nonzero;

   assign tick = en && (presc == PRESC_MAX);

   // Ripple decimal carry/borrow; a carry or borrow out of the top digit marks a boundary.
   always_comb begin
      inc_val   = bcd;
      dec_val   = bcd;
      clamp_val = load_val;
      carry     = 1'b1;
      borrow    = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (bcd[4*i +: 4] == 4'd9) begin
               inc_val[4*i +: 4] = 4'd0;
            end else begin
               inc_val[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
         if (borrow) begin
            if (bcd[4*i +: 4] == 4'd0) begin
               dec_val[4*i +: 4] = 4'd9;
            end else begin
               dec_val[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
               borrow = 1'b0;
            end
         end
         if (load_val[4*i +: 4] > 4'd9) begin
            clamp_val[4*i +: 4] = 4'd9;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
         bcd   <= '0;
         tc    <= 1'b0;
      end else if (clr) begin
         presc <= '0;
         bcd   <= '0;
         tc    <= 1'b0;
      end else begin
         if (en) begin
            presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
         end
         tc <= 1'b0;
         if (load) begin
            bcd <= clamp_val;
         end else if (tick) begin
            // At a boundary, wrap comes for free from the ripple result; saturate holds.
            if (up) begin
               bcd <= (carry && !wrap) ? bcd : inc_val;
               tc  <= carry;
            end else begin
               bcd <= (borrow && !wrap) ? bcd : dec_val;
               tc  <= borrow;
            end
         end
      end
   end

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b0000001;
         4'd1:    return 7'b1001111;
         4'd2:    return 7'b0010010;
         4'd3:    return 7'b0000110;
         4'd4:    return 7'b1001100;
         4'd5:    return 7'b0100100;
         4'd6:    return 7'b0100000;
         4'd7:    return 7'b0001101;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   // Scan from the top digit so a zero is blanked only while nothing nonzero sits above it.
   always_comb begin
      hex          = '1;
      seen_nonzero = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if ((BLANK_LZ != 0) && (i != 0) && !seen_nonzero && (bcd[4*i +: 4] == 4'd0)) begin
            hex[7*i +: 7] = 7'b1111111;
         end else begin
            hex[7*i +: 7] = seg7(bcd[4*i +: 4]);
         end
         if (bcd[4*i +: 4] != 4'd0) begin
            seen_nonzero = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_updown_bcd_timer.sv
// Bench for updown_bcd_timer: a 2-digit instance and a 3-digit blanking instance
// share stimulus and are compared each cycle against an integer-valued model.
module tb_updown_bcd_timer;

   localparam int TICK_DIV = 4;

   logic        clk = 1'b0;
   logic        rst, clr, en, up, wrap, load;
   logic [7:0]  load_val2;
   logic [11:0] load_val3;
   logic [7:0]  bcd2;
   logic [13:0] hex2;
   logic        tc2;
   logic [11:0] bcd3;
   logic [20:0] hex3;
   logic        tc3;

   int   checks_total  = 0;
   int   checks_passed = 0;
   int   checks_failed = 0;
   int   mcnt, mv2, mv3;
   logic mtc2, mtc3;

   updown_bcd_timer #(.DIGITS(2), .TICK_DIV(TICK_DIV), .BLANK_LZ(0)) dut2 (
      .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .wrap(wrap), .load(load),
      .load_val(load_val2), .bcd(bcd2), .hex(hex2), .tc(tc2)
   );

   updown_bcd_timer #(.DIGITS(3), .TICK_DIV(TICK_DIV), .BLANK_LZ(1)) dut3 (
      .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .wrap(wrap), .load(load),
      .load_val(load_val3), .bcd(bcd3), .hex(hex3), .tc(tc3)
   );

   always #5 clk = ~clk;

   function automatic int pow10(input int n);
      int r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0:       return 7'b0000001;
         1:       return 7'b1001111;
         2:       return 7'b0010010;
         3:       return 7'b0000110;
         4:       return 7'b1001100;
         5:       return 7'b0100100;
         6:       return 7'b0100000;
         7:       return 7'b0001101;
         8:       return 7'b0000000;
         9:       return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic int clamp_load(input logic [31:0] lv, input int nd);
      int v = 0;
      int d;
      for (int i = 0; i < nd; i++) begin
         d = int'(lv[4*i +: 4]);
         if (d > 9) d = 9;
         v = v + d * pow10(i);
      end
      return v;
   endfunction

   function automatic logic [31:0] to_bcd(input int v, input int nd);
      logic [31:0] r = '0;
      for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
      return r;
   endfunction

   function automatic logic [31:0] to_hex(input int v, input int nd, input bit blank);
      logic [31:0] r = '0;
      for (int i = 0; i < nd; i++) begin
         if (blank && i > 0 && v < pow10(i)) r[7*i +: 7] = 7'b1111111;
         else                                r[7*i +: 7] = seg_of((v / pow10(i)) % 10);
      end
      return r;
   endfunction

   function automatic int next_val(input int v, input int maxv, input logic dir_up, input logic wr);
      if (dir_up) begin
         if (v == maxv) return wr ? 0 : maxv;
         return v + 1;
      end
      if (v == 0) return wr ? maxv : 0;
      return v - 1;
   endfunction

   function automatic logic at_boundary(input int v, input int maxv, input logic dir_up);
      return dir_up ? (v == maxv) : (v == 0);
   endfunction

   task automatic model_reset();
      mcnt = 0; mv2 = 0; mv3 = 0; mtc2 = 1'b0; mtc3 = 1'b0;
   endtask

   task automatic model_edge();
      logic tick;
      if (rst) begin
         model_reset();
      end else if (clr) begin
         model_reset();
      end else begin
         tick = en && (mcnt == TICK_DIV - 1);
         if (en) mcnt = (mcnt == TICK_DIV - 1) ? 0 : mcnt + 1;
         mtc2 = 1'b0;
         mtc3 = 1'b0;
         if (load) begin
            mv2 = clamp_load(32'(load_val2), 2);
            mv3 = clamp_load(32'(load_val3), 3);
         end else if (tick) begin
            mtc2 = at_boundary(mv2, 99, up);
            mtc3 = at_boundary(mv3, 999, up);
            mv2  = next_val(mv2, 99, up, wrap);
            mv3  = next_val(mv3, 999, up, wrap);
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else begin
         checks_failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("bcd2", 32'(bcd2), to_bcd(mv2, 2));
      check("hex2", 32'(hex2), to_hex(mv2, 2, 1'b0));
      check("tc2",  32'(tc2),  32'(mtc2));
      check("bcd3", 32'(bcd3), to_bcd(mv3, 3));
      check("hex3", 32'(hex3), to_hex(mv3, 3, 1'b1));
      check("tc3",  32'(tc3),  32'(mtc3));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; en = 1'b0; up = 1'b1; wrap = 1'b0; load = 1'b0;
      load_val2 = '0; load_val3 = '0;
      model_reset();
      #2;
      check_all();
      step();

      // Count up from reset: three ticks in twelve enabled cycles
      rst = 1'b0; en = 1'b1; up = 1'b1;
      run(12);

      // Saturating up at 99
      load = 1'b1; load_val2 = 8'h98; load_val3 = 12'h998; wrap = 1'b0;
      step();
      load = 1'b0;
      run(10);

      // Wrapping down from 00
      load = 1'b1; load_val2 = 8'h00; load_val3 = 12'h000; up = 1'b0; wrap = 1'b1;
      step();
      load = 1'b0;
      run(10);

      // Digit clamp on load, then clear beats load
      load = 1'b1; load_val2 = 8'hA5; load_val3 = 12'hFA5;
      step();
      clr = 1'b1;
      step();
      clr = 1'b0; load = 1'b0;

      // Freeze at 09 mid-count
      en = 1'b0; load = 1'b1; load_val2 = 8'h09; load_val3 = 12'h009; up = 1'b1;
      step();
      load = 1'b0; en = 1'b1;
      run(2);
      en = 1'b0;
      run(10);
      en = 1'b1;
      run(6);

      // Leading-zero blanking at 007 and asynchronous reset between edges
      load = 1'b1; load_val2 = 8'h07; load_val3 = 12'h007;
      step();
      load = 1'b0;
      run(3);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      #2;
      rst = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         rst       = ($urandom_range(0, 59) == 0);
         clr       = ($urandom_range(0, 29) == 0);
         load      = ($urandom_range(0, 9) == 0);
         en        = ($urandom_range(0, 3) != 0);
         up        = 1'($urandom_range(0, 1));
         wrap      = 1'($urandom_range(0, 1));
         load_val2 = 8'($urandom);
         load_val3 = 12'($urandom);
         if (($urandom_range(0, 2) == 0) && load) begin
            load_val2 = 8'h99;
            load_val3 = 12'h999;
         end
         if (rst) begin
            #1;
            model_reset();
            check_all();
         end
         step();
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/updown_bcd_timer.md
UPDOWN_BCD_TIMER -- requirements
Module: updown_bcd_timer

Interface
REQ-001 SHALL have parameter DIGITS, default 2, number of BCD digits (legal range 1..8).
REQ-002 SHALL have parameter TICK_DIV, default 50000000, enabled clk cycles per count step (legal range >= 1).
REQ-003 SHALL have parameter BLANK_LZ, default 0; when 1, leading-zero digits are blanked.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clr  input  1  synchronous clear of value and prescaler.
REQ-007 SHALL have port en  input  1  count enable; 0 freezes prescaler and value.
REQ-008 SHALL have port up  input  1  direction: 1 = count up, 0 = count down.
REQ-009 SHALL have port wrap  input  1  boundary mode: 1 = wrap-around, 0 = saturate.
REQ-010 SHALL have port load  input  1  synchronous load of load_val.
REQ-011 SHALL have port load_val  input  4*DIGITS  BCD load value; digit i at [4i+3:4i].
REQ-012 SHALL have port bcd  output  4*DIGITS  current value, BCD; digit 0 is least significant.
REQ-013 SHALL have port hex  output  7*DIGITS  7-segment patterns; digit i at [7i+6:7i]; bit 7i+6 = segment a ... bit 7i = segment g; 0 = lit.
REQ-014 SHALL have port tc  output  1  registered one-cycle pulse on a boundary step.

Function
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 only while en=1; tick asserted when prescaler = TICK_DIV-1 and en=1, prescaler then returns to 0; TICK_DIV=1 gives a tick every enabled cycle.
REQ-016 Per-cycle priority SHALL be clr > load > tick step; when no event is active, value holds.
REQ-017 clr SHALL set value and prescaler to 0 and tc to 0, regardless of en.
REQ-018 load (clr=0) SHALL set value to load_val regardless of en; any digit > 9 is loaded as 9; prescaler unaffected; tc=0 that cycle.
REQ-019 Up step SHALL add 1 in BCD with decimal carry across digits (e.g. 09 -> 10, 19 -> 20).
REQ-020 Down step SHALL subtract 1 in BCD with decimal borrow (e.g. 10 -> 09).
REQ-021 Up step at all-nines: wrap=1 -> all zeros; wrap=0 -> hold all-nines; tc=1 either way.
REQ-022 Down step at all-zeros: wrap=1 -> all-nines; wrap=0 -> hold zero; tc=1 either way.
REQ-023 tc SHALL be 1 only in the cycle following a boundary-step tick (coincident with the updated bcd), else 0.
REQ-024 bcd SHALL be the registered value; hex SHALL be a combinational decode of bcd (zero added latency).
REQ-025 Segment patterns (a..g) SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001101, 8=0000000, 9=0000100; any other code = 1111111.
REQ-026 With BLANK_LZ=1, each zero digit above the most significant nonzero digit SHALL display 1111111; digit 0 is never blanked.
REQ-027 Changes to up or wrap SHALL take effect on the next tick; no effect on prescaler.

Reset
REQ-028 rst=1 SHALL immediately set prescaler=0, bcd=0, tc=0, hex = digit-0 pattern in every field (or blanked upper fields if BLANK_LZ=1), independent of clk.
REQ-029 Deassertion of rst SHALL be followed by the first tick after TICK_DIV enabled cycles.
REQ-030 rst asserted mid-count SHALL discard the partial prescaler count and any pending tc.

Verification (DIGITS=2, TICK_DIV=4 unless noted)
REQ-031 rst pulse, en=1, up=1, 12 cycles -> bcd 00,01,02,03 each step 4 cycles apart; hex[6:0] = 0000001 then 1001111.
REQ-032 load 98, up=1, wrap=0, en=1 -> 99 after one tick with tc=0, next tick holds 99 with tc=1 for one cycle.
REQ-033 load 00, up=0, wrap=1 -> next tick bcd=99, tc=1 one cycle; following tick bcd=98, tc=0.
REQ-034 load_val=8'hA5 -> bcd=95; same cycle clr=1 and load=1 -> bcd=00.
REQ-035 en=0 for 10 cycles mid-count at 09 -> bcd stays 09, prescaler frozen; en=1 -> 10 after the remaining cycles.
REQ-036 BLANK_LZ=1, DIGITS=3, value 007 -> hex fields 2,1 = 1111111, field 0 = 0001101; async rst mid-cycle -> bcd=000 before next clk edge.
